i2c_master_nbyte: RTL and testbench

- Parametrised I2C single-master transaction engine for slave configuration and readback.
- Issues START, address byte, then LEN payload bytes written or read, then STOP.
- SCL rate is set by a clock divider, not tied to CLOCK.
- Reports NACK with an abort-to-STOP, and returns read data.
- Sits between the register-init sequencer and the board I2C pins (SDA open-drain, SCL driven).

---
 rtl/i2c_master_nbyte.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_master_nbyte.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_nbyte.sv
// Single-master I2C engine: START, address byte, LEN payload bytes written or read, then STOP.
// SCL is built from a quarter-period divider; a NACK from the slave aborts straight to STOP.
module i2c_master_nbyte #(
  parameter int MAX_BYTES = 3,
  parameter int CLK_DIV   = 125
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       GO,
  input  logic                       W_R,
  input  logic [3:0]                 LEN,
  input  logic [8*MAX_BYTES-1:0]     I2C_DATA,
  inout  wire                        I2C_SDAT,
  output logic                       I2C_SCLK,
  output logic [8*(MAX_BYTES-1)-1:0] RD_DATA,
  output logic                       END,
  output logic                       BUSY,
  output logic                       ACK
);

  localparam int TW = 8 * MAX_BYTES;
  localparam int RW = 8 * (MAX_BYTES - 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]    LEN_MAX  = 4'(MAX_BYTES - 1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_START    = 4'd1;
  localparam logic [3:0] ST_ADDR     = 4'd2;
  localparam logic [3:0] ST_ADDR_ACK = 4'd3;
  localparam logic [3:0] ST_WR_BYTE  = 4'd4;
  localparam logic [3:0] ST_WR_ACK   = 4'd5;
  localparam logic [3:0] ST_RD_BYTE  = 4'd6;
  localparam logic [3:0] ST_RD_ACK   = 4'd7;
  localparam logic [3:0] ST_STOP     = 4'd8;

  logic [3:0]    state;
  logic [1:0]    quarter;
  logic [2:0]    bit_idx;
  logic [DW-1:0] div;
  logic [TW-1:0] tx;
  logic [7:0]    rx;
  logic [3:0]    rem;
  logic [3:0]    rem_next;
  logic          rw;
  logic          sda_oe;
  logic          ack_bit;
  logic          go_s;
  logic          go_q;
  logic          go_rise;
  logic          tick;

  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
  assign go_rise  = go_s & ~go_q;
  assign tick     = BUSY && (div == DIV_LAST);
  assign rem_next = (rem == 4'd0) ? 4'd0 : rem - 4'd1;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      go_s <= 1'b0;
      go_q <= 1'b0;
    end else begin
      go_s <= GO;
      go_q <= go_s;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      div <= '0;
    else if (!BUSY || tick)
      div <= '0;
    else
      div <= div + DW'(1);
  end

  // Every state advances one quarter per tick; outputs for the next quarter are set on the tick.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      quarter  <= 2'd0;
      bit_idx  <= 3'd0;
      tx       <= '0;
      rx       <= 8'd0;
      rem      <= 4'd0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      ack_bit  <= 1'b0;
      I2C_SCLK <= 1'b1;
      RD_DATA  <= '0;
      END      <= 1'b1;
      BUSY     <= 1'b0;
      ACK      <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (go_rise) begin
        state    <= ST_START;
        quarter  <= 2'd0;
        tx       <= I2C_DATA;
        rw       <= W_R;
        rem      <= (LEN > LEN_MAX) ? LEN_MAX : LEN;
        RD_DATA  <= '0;
        ACK      <= 1'b0;
        END      <= 1'b0;
        BUSY     <= 1'b1;
        I2C_SCLK <= 1'b1;
        sda_oe   <= 1'b0;
      end
    end else if (tick) begin
      quarter <= quarter + 2'd1;
      case (state)
        ST_START: begin
          if (quarter == 2'd0)
            sda_oe <= 1'b1;
          else if (quarter == 2'd1)
            I2C_SCLK <= 1'b0;
          else if (quarter == 2'd3) begin
            state   <= ST_ADDR;
            bit_idx <= 3'd7;
            sda_oe  <= ~tx[TW-1];
          end
        end
        ST_STOP: begin
          if (quarter == 2'd0)
            I2C_SCLK <= 1'b1;
          else if (quarter == 2'd1)
            sda_oe <= 1'b0;
          else if (quarter == 2'd3) begin
            state <= ST_IDLE;
            END   <= 1'b1;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          if (quarter == 2'd1)
            I2C_SCLK <= 1'b1;
          else if (quarter == 2'd2) begin
            ack_bit <= I2C_SDAT;
            rx      <= {rx[6:0], I2C_SDAT};
          end else if (quarter == 2'd3) begin
            I2C_SCLK <= 1'b0;
            case (state)
              ST_ADDR, ST_WR_BYTE: begin
                tx <= {tx[TW-2:0], 1'b0};
                if (bit_idx == 3'd0) begin
                  sda_oe <= 1'b0;
                  state  <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
                  if (state == ST_WR_BYTE)
                    rem <= rem_next;
                end else begin
                  bit_idx <= bit_idx - 3'd1;
                  // The last address bit carries the direction instead of the latched x bit.
                  sda_oe  <= (state == ST_ADDR && bit_idx == 3'd1) ? ~rw : ~tx[TW-2];
                end
              end
              ST_ADDR_ACK, ST_WR_ACK: begin
                if (ack_bit) begin
                  ACK    <= 1'b1;
                  state  <= ST_STOP;
                  sda_oe <= 1'b1;
                end else if (rem == 4'd0) begin
                  state  <= ST_STOP;
                  sda_oe <= 1'b1;
                end else if (!rw) begin
                  state   <= ST_WR_BYTE;
                  bit_idx <= 3'd7;
                  sda_oe  <= ~tx[TW-1];
                end else begin
                  state   <= ST_RD_BYTE;
                  bit_idx <= 3'd7;
                  sda_oe  <= 1'b0;
                end
              end
              ST_RD_BYTE: begin
                if (bit_idx == 3'd0) begin
                  RD_DATA <= (RD_DATA << 8) | RW'(rx);
                  rem     <= rem_next;
                  state   <= ST_RD_ACK;
                  sda_oe  <= (rem_next != 4'd0);
                end else begin
                  bit_idx <= bit_idx - 3'd1;
                end
              end
              ST_RD_ACK: begin
                if (rem == 4'd0) begin
                  state  <= ST_STOP;
                  sda_oe <= 1'b1;
                end else begin
                  state   <= ST_RD_BYTE;
                  bit_idx <= 3'd7;
                  sda_oe  <= 1'b0;
                end
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Bench for i2c_master_nbyte: a decoding slave on the bus plus a byte-level reference model
// of each transaction (bytes, ack slots, read data, ACK flag and GO-to-END latency).
module tb_i2c_master_nbyte;

  localparam int MB    = 3;
  localparam int CD    = 4;
  localparam int LIMIT = 20000;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        GO = 1'b0;
  logic        W_R = 1'b0;
  logic [3:0]  LEN = 4'd0;
  logic [23:0] I2C_DATA = 24'd0;
  wire         sda_bus;
  logic        I2C_SCLK;
  logic [15:0] RD_DATA;
  logic        END;
  logic        BUSY;
  logic        ACK;

  logic        slave_low = 1'b0;
  logic        nack_addr = 1'b0;
  logic [7:0]  rd_bytes[16];

  int          n_compared;
  int          n_mismatched;

  pullup (sda_bus);
  assign sda_bus = slave_low ? 1'b0 : 1'bz;

  always #5 CLOCK = ~CLOCK;

  i2c_master_nbyte #(.MAX_BYTES(MB), .CLK_DIV(CD)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .GO       (GO),
    .W_R      (W_R),
    .LEN      (LEN),
    .I2C_DATA (I2C_DATA),
    .I2C_SDAT (sda_bus),
    .I2C_SCLK (I2C_SCLK),
    .RD_DATA  (RD_DATA),
    .END      (END),
    .BUSY     (BUSY),
    .ACK      (ACK)
  );

  // Slave and bus decoder: START/STOP, bits on SCL rise, slave drives on SCL fall.
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         bit_cnt = 0;
  int         byte_idx = 0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  logic       rw_seen = 1'b0;
  logic       slave_done = 1'b0;
  logic [7:0] shift = 8'd0;
  logic [7:0] mon_bytes[$];
  logic       mon_acks[$];

  always @(negedge CLOCK) begin
    logic       sda_now;
    logic [7:0] cur;
    sda_now = sda_bus;
    if (scl_prev && I2C_SCLK && sda_prev && !sda_now) begin
      start_cnt++;
      bit_cnt    = 0;
      byte_idx   = 0;
      slave_done = 1'b0;
      slave_low  = 1'b0;
    end else if (scl_prev && I2C_SCLK && !sda_prev && sda_now) begin
      stop_cnt++;
      bit_cnt   = 0;
      slave_low = 1'b0;
    end else if (!scl_prev && I2C_SCLK) begin
      if (bit_cnt < 8) begin
        shift = {shift[6:0], sda_now};
        bit_cnt++;
      end else begin
        mon_bytes.push_back(shift);
        mon_acks.push_back(sda_now);
        if (byte_idx == 0)
          rw_seen = shift[0];
        else if (rw_seen && sda_now)
          slave_done = 1'b1;
        byte_idx++;
        bit_cnt = 0;
      end
    end else if (scl_prev && !I2C_SCLK) begin
      slave_low = 1'b0;
      if (bit_cnt == 8) begin
        if (byte_idx == 0)
          slave_low = !nack_addr;
        else if (!rw_seen)
          slave_low = 1'b1;
      end else if (rw_seen && byte_idx >= 1 && byte_idx <= 16 && !slave_done) begin
        cur       = rd_bytes[byte_idx-1];
        slave_low = !cur[3'(7 - bit_cnt)];
      end
    end
    scl_prev = I2C_SCLK;
    sda_prev = sda_now;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one transaction and checks it against the byte-level model.
  task automatic apply_stimulus(input logic rw, input logic [3:0] len, input logic [23:0] data,
                                input logic nack, input logic rego);
    int          b0, s0, p0, cnt, eff, quarters;
    logic        seen;
    logic [15:0] exp_rd;
    logic [7:0]  exp_byte;
    logic        exp_ack;
    b0 = mon_bytes.size();
    s0 = start_cnt;
    p0 = stop_cnt;
    nack_addr = nack;
    W_R = rw;
    LEN = len;
    I2C_DATA = data;
    eff = (int'(len) > MB - 1) ? MB - 1 : int'(len);
    if (nack) eff = 0;
    quarters = 8 + 36 * (1 + eff);
    @(posedge CLOCK);
    #1 GO = 1'b1;
    cnt  = 0;
    seen = 1'b0;
    while (cnt < LIMIT) begin
      @(posedge CLOCK);
      cnt++;
      #1;
      if (rego && cnt == 40) GO = 1'b0;
      if (rego && cnt == 60) GO = 1'b1;
      if (BUSY) seen = 1'b1;
      if (seen && END) break;
    end
    GO = 1'b0;
    check_output("latency", 32'(cnt), 32'(2 + CD * quarters));
    check_output("ack_flag", 32'(ACK), 32'(nack));
    check_output("busy_end", 32'({BUSY, END}), 32'h1);
    check_output("starts", 32'(start_cnt - s0), 1);
    check_output("stops", 32'(stop_cnt - p0), 1);
    check_output("nbytes", 32'(mon_bytes.size() - b0), 32'(1 + eff));
    exp_rd = 16'd0;
    for (int k = 0; k <= eff && b0 + k < mon_bytes.size(); k++) begin
      if (k == 0) begin
        exp_byte = {data[23:17], rw};
        exp_ack  = nack;
      end else if (!rw) begin
        exp_byte = data[23-8*k -: 8];
        exp_ack  = 1'b0;
      end else begin
        exp_byte = rd_bytes[k-1];
        exp_ack  = (k == eff);
        exp_rd   = {exp_rd[7:0], exp_byte};
      end
      check_output($sformatf("byte%0d", k), 32'(mon_bytes[b0+k]), 32'(exp_byte));
      check_output($sformatf("ackslot%0d", k), 32'(mon_acks[b0+k]), 32'(exp_ack));
    end
    check_output("rd_data", 32'(RD_DATA), 32'(exp_rd));
    repeat (3) @(posedge CLOCK);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int k = 0; k < 16; k++) rd_bytes[k] = 8'd0;

    repeat (3) @(posedge CLOCK);
    #1;
    check_output("rst_scl", 32'(I2C_SCLK), 1);
    check_output("rst_sda", 32'(sda_bus), 1);
    check_output("rst_end", 32'(END), 1);
    check_output("rst_busy", 32'(BUSY), 0);
    check_output("rst_ack", 32'(ACK), 0);
    check_output("rst_rd", 32'(RD_DATA), 0);
    RESET = 1'b1;
    repeat (2) @(posedge CLOCK);

    $display("[TB] directed transactions");
    apply_stimulus(1'b0, 4'd2, 24'h341A5F, 1'b0, 1'b0);
    rd_bytes[0] = 8'hA5;
    rd_bytes[1] = 8'h3C;
    apply_stimulus(1'b1, 4'd2, 24'h350000, 1'b0, 1'b0);
    check_output("rd_a53c", 32'(RD_DATA), 32'h0000A53C);
    apply_stimulus(1'b0, 4'd2, 24'h341A5F, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'd0, 24'h5A0000, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd2, 24'h341A5F, 1'b0, 1'b1);

    $display("[TB] reset during write byte");
    W_R = 1'b0;
    LEN = 4'd2;
    I2C_DATA = 24'h341A5F;
    nack_addr = 1'b0;
    @(posedge CLOCK);
    #1 GO = 1'b1;
    repeat (2 + CD * 50) @(posedge CLOCK);
    #1;
    check_output("busy_pre_reset", 32'(BUSY), 1);
    RESET = 1'b0;
    #1;
    check_output("mid_rst_scl", 32'(I2C_SCLK), 1);
    check_output("mid_rst_sda", 32'(sda_bus), 1);
    check_output("mid_rst_end", 32'(END), 1);
    check_output("mid_rst_busy", 32'(BUSY), 0);
    check_output("mid_rst_ack", 32'(ACK), 0);
    GO = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1 RESET = 1'b1;
    repeat (2) @(posedge CLOCK);
    apply_stimulus(1'b0, 4'd2, 24'hC396E1, 1'b0, 1'b0);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 16; k++) rd_bytes[k] = 8'($urandom_range(0, 255));
      apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 24'($urandom),
                     ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
